j1_irq_controller: RTL and testbench

- Memory-mapped interrupt controller on the 64-bit j1 IO bus; drives the core's single interrupt_request input.
- Synchronises NSRC external sources and latches their rising edges as pending bits, with per-source enables and fixed lowest-index priority.
- Sequences a claim / end-of-interrupt handshake so the handler at 0x0008 sees exactly one cause per entry.

---
 rtl/j1_irq_controller_if.sv | 12 +
 rtl/j1_irq_controller.sv | 128 ++++++++++++
 tb/tb_j1_irq_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_irq_controller_if.sv
// j1 IO bus seen by a memory-mapped peripheral: one-cycle rd/wr strobes,
// a 64-bit byte address, write data, and registered read data.
interface j1_irq_controller_if;
  logic        io_rd;
  logic        io_wr;
  logic [63:0] io_addr;
  logic [63:0] io_dout;
  logic [63:0] io_din;

  modport master (output io_rd, io_wr, io_addr, io_dout, input  io_din);
  modport slave  (input  io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/j1_irq_controller.sv
// Interrupt controller for the j1 core: edge-latched pending bits, enables,
// lowest-index priority and a claim / end-of-interrupt handshake.
module j1_irq_controller #(
  parameter int          NSRC = 8,
  parameter logic [63:0] BASE = 64'h0000_0000_0001_0000
) (
  input  logic                clk,
  input  logic                reset,
  j1_irq_controller_if.slave  io,
  input  logic [NSRC-1:0]     irq_src,
  output logic                interrupt_request
);

  typedef enum logic {IDLE, SERVICE} state_t;

  typedef enum logic [2:0] {
    OFF_PENDING = 3'd0,
    OFF_ENABLE  = 3'd1,
    OFF_CAUSE   = 3'd2,
    OFF_SWSET   = 3'd3,
    OFF_EOI     = 3'd4,
    OFF_STATUS  = 3'd5
  } reg_off_t;

  state_t          state, state_next;
  logic [NSRC-1:0] sync1, sync2, prev_q;
  logic [NSRC-1:0] pending, pending_next, enable;
  logic [NSRC-1:0] active, rise, win_onehot, set_mask, clr_mask;
  logic [5:0]      winner;
  logic [63:0]     rd_data, din_q;
  logic [2:0]      offset;
  logic            sel, wr_hit, rd_hit, claim, any_active;
  logic            unused_bits;

  assign sel    = (io.io_addr[63:6] == BASE[63:6]);
  assign offset = io.io_addr[5:3];
  // A colliding read is dropped so the write is the only effect.
  assign wr_hit = io.io_wr & sel;
  assign rd_hit = io.io_rd & ~io.io_wr & sel;

  assign rise       = sync2 & ~prev_q;
  assign active     = pending & enable;
  assign any_active = |active;
  assign io.io_din  = din_q;
  assign unused_bits = ^{io.io_addr[2:0], io.io_dout[63:NSRC]};

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    winner     = '0;
    win_onehot = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner        = 6'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    claim      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_hit && offset == OFF_CAUSE && any_active) begin
          claim      = 1'b1;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (wr_hit && offset == OFF_EOI) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sets are applied after clears so a same-cycle set always wins.
  always_comb begin
    clr_mask = claim ? win_onehot : '0;
    set_mask = rise;
    if (wr_hit && offset == OFF_PENDING) clr_mask = clr_mask | io.io_dout[NSRC-1:0];
    if (wr_hit && offset == OFF_SWSET)   set_mask = set_mask | io.io_dout[NSRC-1:0];
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (offset)
        OFF_PENDING: rd_data = 64'(pending);
        OFF_ENABLE:  rd_data = 64'(enable);
        OFF_CAUSE:   rd_data = claim ? {1'b1, 57'b0, winner} : 64'b0;
        OFF_STATUS:  rd_data = {62'b0, state == SERVICE, interrupt_request};
        default:     rd_data = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1             <= '0;
      sync2             <= '0;
      prev_q            <= '0;
      pending           <= '0;
      enable            <= '0;
      interrupt_request <= 1'b0;
      din_q             <= '0;
    end else begin
      sync1   <= irq_src;
      sync2   <= sync1;
      prev_q  <= sync2;
      pending <= pending_next;
      if (wr_hit && offset == OFF_ENABLE) enable <= io.io_dout[NSRC-1:0];
      interrupt_request <= (state_next == IDLE) && any_active;
      if (io.io_rd) din_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_j1_irq_controller.sv
// Randomised scoreboard bench for j1_irq_controller against an abstract
// model of pending/enable/service state.
module tb_j1_irq_controller;
  localparam int          NSRC = 8;
  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic            interrupt_request;

  always #5 clk = ~clk;

  j1_irq_controller_if bus ();

  j1_irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .io(bus),
    .irq_src(irq_src),
    .interrupt_request(interrupt_request)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  // Abstract model: pending set, enable set, and whether a handler is running.
  logic [NSRC-1:0] m_pend, m_en;
  bit              m_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic m_irq();
    return !m_busy && (|(m_pend & m_en));
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus.io_rd = rd; bus.io_wr = wr; bus.io_addr = addr; bus.io_dout = data;
    @(negedge clk);
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_dout = '0;
  endtask

  task automatic wr_reg(input int off, input logic [63:0] data);
    case (off)
      0: m_pend = m_pend & ~data[NSRC-1:0];
      1: m_en   = data[NSRC-1:0];
      3: m_pend = m_pend | data[NSRC-1:0];
      4: m_busy = 1'b0;
      default: ;
    endcase
    drive(1'b0, 1'b1, BASE + 64'(off * 8), data);
  endtask

  task automatic rd_reg(input string name, input int off);
    exp_t e;
    e.name = name;
    e.exp  = '0;
    case (off)
      0: e.exp = 64'(m_pend);
      1: e.exp = 64'(m_en);
      2: begin
        if (!m_busy && |(m_pend & m_en)) begin
          for (int i = 0; i < NSRC; i++) begin
            if ((m_pend[i] & m_en[i]) && !m_busy) begin
              e.exp     = {1'b1, 57'b0, 6'(i)};
              m_pend[i] = 1'b0;
              m_busy    = 1'b1;
            end
          end
        end
      end
      5: e.exp = {62'b0, m_busy, m_irq()};
      default: e.exp = '0;
    endcase
    sb.push_back(e);
    drive(1'b1, 1'b0, BASE + 64'(off * 8), '0);
  endtask

  task automatic rd_raw(input string name, input logic [63:0] addr);
    exp_t e;
    e.name = name;
    e.exp  = '0;
    sb.push_back(e);
    drive(1'b1, 1'b0, addr, '0);
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    @(negedge clk) irq_src = mask;
    @(negedge clk) irq_src = '0;
    settle(4);
    m_pend = m_pend | mask;
  endtask

  task automatic chk_irq(input string name);
    check(name, 64'(interrupt_request), 64'(m_irq()));
  endtask

  // Monitor: every read strobe yields io_din one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.io_rd === 1'b1 && reset === 1'b0) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got io_din %h with no expected entry", bus.io_din);
        end else begin
          e = sb.pop_front();
          check(e.name, bus.io_din, e.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NSRC-1:0] r;
    reset = 1'b1;
    irq_src = '0;
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_dout = '0;
    m_pend = '0; m_en = '0; m_busy = 1'b0;
    settle(3);
    reset = 1'b0;
    check("rst_irq", 64'(interrupt_request), 64'd0);
    check("rst_din", bus.io_din, 64'd0);

    // Edge latency: pending after 3 clk, request one clk later.
    wr_reg(1, 64'h01);
    @(negedge clk) irq_src = 8'h01;
    @(negedge clk) irq_src = '0;
    @(negedge clk) check("t1_irq_c2", 64'(interrupt_request), 64'd0);
    @(negedge clk) check("t1_irq_c3", 64'(interrupt_request), 64'd0);
    @(negedge clk) check("t1_irq_c4", 64'(interrupt_request), 64'd1);
    m_pend = 8'h01;
    rd_reg("t1_cause", 2);
    check("t1_irq_drop", 64'(interrupt_request), 64'd0);
    rd_reg("t1_pend", 0);
    rd_reg("t1_status", 5);
    wr_reg(4, 64'd0);
    settle(2);
    rd_reg("t1_status_eoi", 5);

    // Priority between simultaneous edges.
    wr_reg(1, 64'hFF);
    pulse(8'h24);
    chk_irq("t2_irq");
    rd_reg("t2_cause_first", 2);
    settle(3);
    chk_irq("t2_irq_held");
    wr_reg(4, 64'd0);
    settle(2);
    chk_irq("t2_irq_reassert");
    rd_reg("t2_cause_second", 2);
    wr_reg(4, 64'd0);
    settle(2);

    // Masking, then enabling asserts the request one clk after the write.
    wr_reg(1, 64'h00);
    pulse(8'h08);
    rd_reg("t3_pend", 0);
    chk_irq("t3_irq_masked");
    wr_reg(1, 64'h08);
    check("t3_irq_same", 64'(interrupt_request), 64'd0);
    @(negedge clk) check("t3_irq_next", 64'(interrupt_request), 64'd1);
    wr_reg(1, 64'h00);
    wr_reg(0, 64'h08);

    // W1C on the same edge that a new rise re-sets the bit.
    pulse(8'h10);
    @(negedge clk) irq_src = 8'h10;
    @(negedge clk) irq_src = '0;
    @(negedge clk);
    bus.io_wr = 1'b1; bus.io_addr = BASE; bus.io_dout = 64'h10;
    @(negedge clk);
    bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_dout = '0;
    settle(3);
    rd_reg("t4_collide", 0);
    wr_reg(0, 64'h10);
    rd_reg("t4_cleared", 0);
    wr_reg(1, 64'h40);
    wr_reg(3, 64'h40);
    settle(2);
    chk_irq("t4_swset_irq");
    rd_reg("t4_swset_cause", 2);
    wr_reg(4, 64'd0);
    wr_reg(1, 64'h00);
    settle(2);

    // Handshake corners and decode boundaries.
    rd_reg("t5_cause_empty", 2);
    wr_reg(4, 64'd0);
    rd_reg("t5_status_idle", 5);
    wr_reg(1, 64'h03);
    wr_reg(3, 64'h03);
    settle(2);
    rd_reg("t5_cause_idx0", 2);
    rd_reg("t5_cause_busy", 2);
    rd_reg("t5_pend_busy", 0);
    rd_raw("t5_off7", BASE + 64'h38);
    rd_raw("t5_next_win", BASE + 64'h40);
    wr_reg(3, 64'h01);
    rd_reg("t5_pend_pre_rst", 0);

    // Asynchronous reset while in service.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_irq_rst", 64'(interrupt_request), 64'd0);
    check("t6_din_rst", bus.io_din, 64'd0);
    settle(2);
    reset = 1'b0;
    m_pend = '0; m_en = '0; m_busy = 1'b0;
    rd_reg("t6_status", 5);
    rd_reg("t6_pend", 0);

    // Simultaneous rd+wr: write lands, read returns 0.
    m_en = 8'h5A;
    sb.push_back('{name: "t7_rdwr", exp: 64'd0});
    drive(1'b1, 1'b1, BASE + 64'h08, 64'h5A);
    rd_reg("t7_en", 1);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      r = NSRC'($urandom);
      case ($urandom_range(0, 9))
        0: wr_reg(1, 64'(r));
        1: pulse(r);
        2: wr_reg(3, 64'(r & NSRC'($urandom)));
        3: wr_reg(0, 64'(r));
        4, 5: rd_reg("rnd_cause", 2);
        6: wr_reg(4, 64'($urandom));
        7: rd_reg("rnd_reg", int'($urandom_range(0, 7)));
        8: rd_raw("rnd_unmapped", BASE + 64'h40 + 64'($urandom_range(0, 63) * 8));
        default: drive(1'b0, 1'b1, BASE + 64'h48, 64'(r));
      endcase
      settle(2);
      chk_irq("rnd_irq");
    end

    settle(4);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
